// File: rtl/thistle_pkg.sv
// Shared constants and arbiter state encoding for the RAM sharing logic.
package thistle_pkg;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    ST_CPU     = 2'b00,
    ST_WAIT    = 2'b01,
    ST_LOAD    = 2'b10,
    ST_RELEASE = 2'b11
  } arb_state_t;

endpackage

// File: rtl/arb_wait_timer.sv
// Wait timer: counts cycles spent waiting for a CPU boundary; flags the last allowed cycle.
module arb_wait_timer #(
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc_c
);

  localparam int unsigned CNT_W = 8;

  logic [CNT_W-1:0] count;

  // Clear has priority over increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc_c = (count == CNT_W'(WAIT_MAX - 1));

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates the single program/data RAM between the CPU datapath and the program loader.
module ram_arbiter
  import thistle_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_ri,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_boundary,
  input  logic              cpu_hlt,
  output logic              cpu_hold,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ld_req,
  output logic              ld_gnt,
  output logic              ld_nack,
  input  logic              ld_valid,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_rvalid,
  output logic [ADDR_W:0]   ld_wr_cnt,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [ADDR_W:0] WR_CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  arb_state_t state;
  arb_state_t state_nxt;
  logic       nack_nxt;
  logic       tmr_clr;
  logic       tmr_inc;
  logic       tmr_tc;
  logic       load_rd;
  logic       load_wr;

  arb_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (tmr_clr),
    .inc  (tmr_inc),
    .tc_c (tmr_tc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_CPU;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a dropped request always wins, then a boundary grant, then timeout.
  always_comb begin
    state_nxt = state;
    nack_nxt  = 1'b0;
    tmr_clr   = 1'b0;
    tmr_inc   = 1'b0;
    case (state)
      ST_CPU: begin
        if (ld_req) begin
          state_nxt = ST_WAIT;
          tmr_clr   = 1'b1;
        end
      end
      ST_WAIT: begin
        if (!ld_req) begin
          state_nxt = ST_RELEASE;
        end else if (cpu_boundary || cpu_hlt) begin
          state_nxt = ST_LOAD;
        end else if (tmr_tc) begin
          state_nxt = ST_RELEASE;
          nack_nxt  = 1'b1;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      ST_LOAD: begin
        if (!ld_req) begin
          state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!ld_req) begin
          state_nxt = ST_CPU;
        end
      end
      default: state_nxt = ST_CPU;
    endcase
  end

  assign load_rd = (state == ST_LOAD) && ld_valid && !ld_we;
  assign load_wr = (state == ST_LOAD) && ld_valid && ld_we;

  // Registered handshake outputs, derived from the upcoming state.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_hold  <= 1'b0;
      ld_gnt    <= 1'b0;
      ld_nack   <= 1'b0;
      ld_rvalid <= 1'b0;
      ld_wr_cnt <= '0;
    end else begin
      cpu_hold  <= (state_nxt != ST_CPU);
      ld_gnt    <= (state_nxt == ST_LOAD);
      ld_nack   <= nack_nxt;
      ld_rvalid <= load_rd;
      if ((state == ST_WAIT) && (state_nxt == ST_LOAD)) begin
        ld_wr_cnt <= '0;
      end else if (load_wr && (ld_wr_cnt != WR_CNT_MAX)) begin
        ld_wr_cnt <= ld_wr_cnt + (ADDR_W + 1)'(1);
      end
    end
  end

  // RAM port mux: CPU owns the RAM except while the loader is granted; no writes during release.
  always_comb begin
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    ram_we    = cpu_ri;
    case (state)
      ST_LOAD: begin
        ram_addr  = ld_addr;
        ram_wdata = ld_wdata;
        ram_we    = ld_valid && ld_we;
      end
      ST_RELEASE: ram_we = 1'b0;
      default: ;
    endcase
  end

  assign cpu_rdata = ram_rdata;
  assign ld_rdata  = ram_rdata;

  // The sequencer is frozen while the loader owns the RAM, so it must not strobe a write.
  a_no_cpu_ri_when_held : assert property (
    @(posedge clk) disable iff (rst)
      ((state == ST_LOAD) || (state == ST_RELEASE)) |-> !cpu_ri
  ) else $error("cpu_ri asserted while loader owns RAM");

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized scoreboard bench for ram_arbiter with a behavioural RAM and ownership model.
module tb_ram_arbiter;
  import thistle_pkg::*;

  localparam int unsigned WAIT_MAX = 4;
  localparam int unsigned DEPTH    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_ri;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_boundary;
  logic              cpu_hlt;
  logic              cpu_hold;
  logic [DATA_W-1:0] cpu_rdata;
  logic              ld_req;
  logic              ld_gnt;
  logic              ld_nack;
  logic              ld_valid;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic [DATA_W-1:0] ld_rdata;
  logic              ld_rvalid;
  logic [ADDR_W:0]   ld_wr_cnt;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  int n_vec = 0;
  int n_err = 0;
  int wr_exp = 0;

  logic [DATA_W-1:0] ref_mem [DEPTH] = '{default: '0};
  logic [DATA_W-1:0] tb_mem  [DEPTH] = '{default: '0};
  logic [DATA_W-1:0] sb_q [$];

  ram_arbiter #(
    .WAIT_MAX (WAIT_MAX)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_addr     (cpu_addr),
    .cpu_ri       (cpu_ri),
    .cpu_wdata    (cpu_wdata),
    .cpu_boundary (cpu_boundary),
    .cpu_hlt      (cpu_hlt),
    .cpu_hold     (cpu_hold),
    .cpu_rdata    (cpu_rdata),
    .ld_req       (ld_req),
    .ld_gnt       (ld_gnt),
    .ld_nack      (ld_nack),
    .ld_valid     (ld_valid),
    .ld_we        (ld_we),
    .ld_addr      (ld_addr),
    .ld_wdata     (ld_wdata),
    .ld_rdata     (ld_rdata),
    .ld_rvalid    (ld_rvalid),
    .ld_wr_cnt    (ld_wr_cnt),
    .ram_addr     (ram_addr),
    .ram_we       (ram_we),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous RAM macro stand-in: read-before-write, one cycle latency.
  always @(posedge clk) begin
    if (ram_we) tb_mem[ram_addr] <= ram_wdata;
    ram_rdata <= tb_mem[ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every loader read return is matched against the oldest expected value.
  always @(negedge clk) begin
    if (ld_rvalid) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rvalid_unexpected: got ld_rdata 0x%0h with nothing outstanding", ld_rdata);
      end else begin
        check("ld_rdata", 32'(ld_rdata), 32'(sb_q.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Random CPU traffic while the CPU owns the RAM; loader strobes must be ignored.
  task automatic cpu_ops(input int n);
    logic [DATA_W-1:0] exp;
    for (int i = 0; i < n; i++) begin
      cpu_addr  = ADDR_W'($urandom);
      cpu_ri    = 1'($urandom);
      cpu_wdata = DATA_W'($urandom);
      ld_valid  = 1'($urandom);
      ld_we     = 1'b1;
      ld_addr   = ADDR_W'($urandom);
      ld_wdata  = DATA_W'($urandom);
      #1;
      check("cpu_ram_addr", 32'(ram_addr), 32'(cpu_addr));
      check("cpu_ram_we", 32'(ram_we), 32'(cpu_ri));
      check("cpu_ram_wdata", 32'(ram_wdata), 32'(cpu_wdata));
      exp = ref_mem[cpu_addr];
      if (cpu_ri) ref_mem[cpu_addr] = cpu_wdata;
      tick();
      check("cpu_rdata", 32'(cpu_rdata), 32'(exp));
      check("cpu_hold_idle", 32'(cpu_hold), 32'(0));
    end
    cpu_ri   = 1'b0;
    ld_valid = 1'b0;
  endtask

  // Raise the request; CPU becomes ready from cycle f on. Grant or nack timing follows
  // from counting WAIT cycles (cycles 1..WAIT_MAX) against the first ready cycle.
  task automatic request(input int f, input bit use_hlt, output bit granted);
    int r;
    int ev;
    r       = (f < 1) ? 1 : f;
    granted = (r <= int'(WAIT_MAX));
    ev      = granted ? r + 1 : int'(WAIT_MAX) + 1;
    ld_req  = 1'b1;
    cpu_ri  = 1'b0;
    for (int c = 0; c < ev; c++) begin
      cpu_boundary = !use_hlt && (c >= f);
      cpu_hlt      = use_hlt && (c >= f);
      cpu_addr     = ADDR_W'($urandom);
      #1;
      check("wait_ram_addr", 32'(ram_addr), 32'(cpu_addr));
      check("wait_ram_we", 32'(ram_we), 32'(0));
      tick();
      if (c + 1 < ev) begin
        check("wait_hold", 32'(cpu_hold), 32'(1));
        check("wait_gnt", 32'(ld_gnt), 32'(0));
        check("wait_nack", 32'(ld_nack), 32'(0));
      end
    end
    check("event_gnt", 32'(ld_gnt), 32'(granted));
    check("event_nack", 32'(ld_nack), 32'(!granted));
    check("event_hold", 32'(cpu_hold), 32'(1));
    cpu_boundary = 1'b0;
    cpu_hlt      = 1'b0;
    if (granted) begin
      wr_exp = 0;
      check("wr_cnt_clear", 32'(ld_wr_cnt), 32'(0));
    end
  endtask

  // After a nack: RELEASE holds while ld_req stays high, then returns to CPU.
  task automatic release_nack(input int k);
    for (int i = 0; i < k; i++) begin
      tick();
      check("rel_nack_pulse", 32'(ld_nack), 32'(0));
      check("rel_hold", 32'(cpu_hold), 32'(1));
      check("rel_gnt", 32'(ld_gnt), 32'(0));
    end
    ld_req = 1'b0;
    tick();
    check("rel_nack_end", 32'(ld_nack), 32'(0));
    check("rel_hold_drop", 32'(cpu_hold), 32'(0));
  endtask

  // Random loader session; ld_req falls together with the last access.
  task automatic load_ops(input int n, input bit end_read);
    bit v;
    bit w;
    bit last;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    for (int i = 0; i < n; i++) begin
      last = (i == n - 1);
      v = ($urandom % 4) != 0;
      w = 1'($urandom);
      a = ADDR_W'($urandom);
      d = DATA_W'($urandom);
      if (last && end_read) begin
        v = 1'b1;
        w = 1'b0;
      end
      if (last) ld_req = 1'b0;
      ld_valid = v; ld_we = w; ld_addr = a; ld_wdata = d;
      cpu_addr = ADDR_W'($urandom);
      #1;
      check("load_ram_we", 32'(ram_we), 32'(v && w));
      check("load_ram_addr", 32'(ram_addr), 32'(a));
      if (v && w) begin
        check("load_ram_wdata", 32'(ram_wdata), 32'(d));
        ref_mem[a] = d;
        if (wr_exp < int'(DEPTH)) wr_exp++;
      end
      if (v && !w) sb_q.push_back(ref_mem[a]);
      tick();
      check("load_wr_cnt", 32'(ld_wr_cnt), 32'(wr_exp));
      check("load_rvalid", 32'(ld_rvalid), 32'(v && !w));
      check("load_gnt", 32'(ld_gnt), 32'(!last));
      check("load_hold", 32'(cpu_hold), 32'(1));
    end
    // RELEASE: a stray loader write must not reach the RAM.
    ld_valid = 1'b1;
    ld_we    = 1'b1;
    #1;
    check("release_ram_we", 32'(ram_we), 32'(0));
    ld_valid = 1'b0;
    tick();
    check("post_hold", 32'(cpu_hold), 32'(0));
    check("post_wr_cnt", 32'(ld_wr_cnt), 32'(wr_exp));
  endtask

  initial begin
    bit g;
    rst = 1'b1;
    cpu_addr = '0; cpu_ri = 1'b0; cpu_wdata = '0; cpu_boundary = 1'b0; cpu_hlt = 1'b0;
    ld_req = 1'b0; ld_valid = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
    tick();
    tick();
    check("rst_hold", 32'(cpu_hold), 32'(0));
    check("rst_gnt", 32'(ld_gnt), 32'(0));
    check("rst_nack", 32'(ld_nack), 32'(0));
    check("rst_rvalid", 32'(ld_rvalid), 32'(0));
    check("rst_wr_cnt", 32'(ld_wr_cnt), 32'(0));
    rst = 1'b0;

    // CPU write then read-back of address 3.
    cpu_addr = 4'h3; cpu_ri = 1'b1; cpu_wdata = 8'h5A;
    #1;
    check("t1_ram_we", 32'(ram_we), 32'(1));
    check("t1_ram_addr", 32'(ram_addr), 32'(3));
    ref_mem[3] = 8'h5A;
    tick();
    cpu_ri = 1'b0;
    tick();
    check("t1_cpu_rdata", 32'(cpu_rdata), 32'(8'h5A));

    // Boundary arrives on the last permitted WAIT cycle: grant beats timeout.
    request(4, 1'b0, g);
    for (int a = 0; a < int'(DEPTH); a++) begin
      ld_valid = 1'b1; ld_we = 1'b1; ld_addr = ADDR_W'(a); ld_wdata = DATA_W'(a);
      ref_mem[a] = DATA_W'(a);
      tick();
      check("fill_wr_cnt", 32'(ld_wr_cnt), 32'(a + 1));
    end
    ld_addr = '0; ld_wdata = '0;
    tick();
    check("wr_cnt_saturate", 32'(ld_wr_cnt), 32'(16));
    wr_exp = 16;
    ld_we = 1'b0; ld_addr = 4'h5;
    sb_q.push_back(ref_mem[5]);
    tick();
    check("rd5_rvalid", 32'(ld_rvalid), 32'(1));
    check("rd5_rdata", 32'(ld_rdata), 32'(8'h05));
    ld_valid = 1'b0; ld_req = 1'b0;
    tick();
    check("rd5_rel_gnt", 32'(ld_gnt), 32'(0));
    check("rd5_rel_hold", 32'(cpu_hold), 32'(1));
    tick();
    check("rd5_cpu_hold", 32'(cpu_hold), 32'(0));
    check("rd5_wr_cnt_kept", 32'(ld_wr_cnt), 32'(16));

    // CPU never ready: timeout nack, RELEASE held until ld_req drops.
    request(9, 1'b0, g);
    release_nack(2);

    // Request withdrawn while waiting: release without nack.
    ld_req = 1'b1;
    tick();
    check("drop_wait_hold", 32'(cpu_hold), 32'(1));
    ld_req = 1'b0;
    tick();
    check("drop_rel_hold", 32'(cpu_hold), 32'(1));
    check("drop_rel_nack", 32'(ld_nack), 32'(0));
    check("drop_rel_gnt", 32'(ld_gnt), 32'(0));
    tick();
    check("drop_cpu_hold", 32'(cpu_hold), 32'(0));

    // Halted CPU: grant without a boundary; last access is a read returning in RELEASE.
    request(0, 1'b1, g);
    load_ops(5, 1'b1);

    // Reset while granted with a read issued in the same cycle.
    request(1, 1'b0, g);
    ld_valid = 1'b1; ld_we = 1'b1; ld_addr = 4'h9; ld_wdata = 8'hC3;
    ref_mem[9] = 8'hC3;
    tick();
    check("pre_rst_wr_cnt", 32'(ld_wr_cnt), 32'(1));
    ld_we = 1'b0; ld_req = 1'b0; rst = 1'b1;
    tick();
    check("mid_rst_gnt", 32'(ld_gnt), 32'(0));
    check("mid_rst_hold", 32'(cpu_hold), 32'(0));
    check("mid_rst_rvalid", 32'(ld_rvalid), 32'(0));
    check("mid_rst_wr_cnt", 32'(ld_wr_cnt), 32'(0));
    rst = 1'b0; ld_valid = 1'b0;
    wr_exp = 0;

    // Randomized sessions.
    for (int s = 0; s < 25; s++) begin
      cpu_ops(2 + int'($urandom % 4));
      request(int'($urandom_range(0, 6)), 1'($urandom), g);
      if (g) load_ops(1 + int'($urandom % 20), 1'($urandom));
      else   release_nack(int'($urandom % 3));
    end
    cpu_ops(3);
    tick();
    tick();
    check("scoreboard_drained", 32'(sb_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
